// File: rtl/ascon_host_pkg.sv
// ascon_host_pkg: shared state encoding, default widths and serial-counter sizing for the Ascon hash host
package ascon_host_pkg;
    typedef enum logic [2:0] {
        IDLE,
        DRST,
        STREAM,
        ARM,
        START,
        WAIT_READY,
        COLLECT
    } state_t;
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a > b ? a : b;
        return m > c ? m : c;
    endfunction
    localparam int Y_DEF = 32;
    localparam int L_DEF = 256;
    localparam int RW_DEF = 64;
    localparam int N = max3(Y_DEF, L_DEF, RW_DEF);
    localparam int CW = $clog2(N + 2);
endpackage

// File: rtl/ascon_hash_serial_host_if.sv
// ascon_hash_serial_host_if: parallel job/result bundle between harness and host
//   job_valid/job_ready : job handshake
//   msg, msk1, msk2     : message and masking shares (Y bits)
//   rnd                 : 7 permutation randomness words, word k = rnd[k*RW +: RW]
//   rfault              : fault randomness (L bits)
//   hash, hash_valid    : collected hash and its one-cycle completion pulse
//   err                 : sticky watchdog error
//   master = harness side, slave = host side
interface ascon_hash_serial_host_if #(
    parameter int Y = 32,
    parameter int L = 256,
    parameter int RW = 64
) ();
    logic            job_valid;
    logic            job_ready;
    logic [Y-1:0]    msg;
    logic [Y-1:0]    msk1;
    logic [Y-1:0]    msk2;
    logic [7*RW-1:0] rnd;
    logic [L-1:0]    rfault;
    logic [L-1:0]    hash;
    logic            hash_valid;
    logic            err;
    modport master (
        output job_valid, msg, msk1, msk2, rnd, rfault,
        input  job_ready, hash, hash_valid, err
    );
    modport slave (
        input  job_valid, msg, msk1, msk2, rnd, rfault,
        output job_ready, hash, hash_valid, err
    );
endinterface

// File: rtl/ascon_piso.sv
// ascon_piso: parallel-load shift register emitting its MSB first, zero filled behind
//   clk, rst : clock, synchronous active-low reset
//   load     : capture din
//   shift    : shift one place toward the MSB
//   din      : parallel word (W bits)
//   dout     : current MSB
module ascon_piso #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         dout
);
    logic [W-1:0] r;
    always_ff @(posedge clk) begin
        if (!rst) r <= '0;
        else if (load) r <= din;
        else if (shift) r <= {r[W-2:0], 1'b0};
    end
    assign dout = r[W-1];
endmodule

// File: rtl/ascon_hash_serial_host.sv
// ascon_hash_serial_host: serialises one Ascon hash job into the bit-serial core and collects its hash
//   clk, rst      : clock, synchronous active-low reset
//   host          : job/result bundle (slave modport)
//   dut_rstxSO    : active-high reset to the core
//   messagexSO    : serial {msk2, msk1, msg} bits, MSB first
//   r_64xSO       : serial randomness bits, bit k from word k
//   r_faultxSO    : serial fault-randomness bit
//   startxSO      : start pulse to the core
//   hash_textxSI  : serial hash bit from the core, LSB first
//   readyxSI      : core ready
// Optional: define ASCON_HOST_TIMEOUT_EN for a WAIT_READY watchdog (TO_CYC cycles) driving host.err.
module ascon_hash_serial_host
    import ascon_host_pkg::*;
#(
    parameter int Y = Y_DEF,
    parameter int L = L_DEF,
    parameter int RW = RW_DEF
`ifdef ASCON_HOST_TIMEOUT_EN
    , parameter int TO_CYC = 4096
`endif
) (
    input  logic                      clk,
    input  logic                      rst,
    ascon_hash_serial_host_if.slave   host,
    output logic                      dut_rstxSO,
    output logic [2:0]                messagexSO,
    output logic [6:0]                r_64xSO,
    output logic                      r_faultxSO,
    output logic                      startxSO,
    input  logic                      hash_textxSI,
    input  logic                      readyxSI
);
    localparam int NS = max3(Y, L, RW);
    localparam int CNTW = $clog2(NS + 2);
    localparam int HW = $clog2(L);
    state_t state, state_n;
    logic [CNTW-1:0] cnt;
    logic ready_d;
    logic rst_pend;
    logic to_fire;
    logic load;
    logic shift;
    logic [2:0] msg_bits;
    logic [6:0] rnd_bits;
    logic flt_bit;
    assign load = state == IDLE && host.job_valid;
    assign shift = state == STREAM;
    ascon_piso #(.W(Y)) u_msg (.clk(clk), .rst(rst), .load(load), .shift(shift), .din(host.msg), .dout(msg_bits[0]));
    ascon_piso #(.W(Y)) u_msk1 (.clk(clk), .rst(rst), .load(load), .shift(shift), .din(host.msk1), .dout(msg_bits[1]));
    ascon_piso #(.W(Y)) u_msk2 (.clk(clk), .rst(rst), .load(load), .shift(shift), .din(host.msk2), .dout(msg_bits[2]));
    ascon_piso #(.W(L)) u_flt (.clk(clk), .rst(rst), .load(load), .shift(shift), .din(host.rfault), .dout(flt_bit));
    for (genvar k = 0; k < 7; k++) begin : g_rnd
        ascon_piso #(.W(RW)) u_rnd (
            .clk(clk), .rst(rst), .load(load), .shift(shift),
            .din(host.rnd[k*RW +: RW]), .dout(rnd_bits[k])
        );
    end
`ifdef ASCON_HOST_TIMEOUT_EN
    localparam int TW = $clog2(TO_CYC + 1);
    logic [TW-1:0] wd;
    logic err_q;
    always_ff @(posedge clk) begin
        if (!rst) begin
            wd <= '0;
            err_q <= 1'b0;
        end else begin
            wd <= state == WAIT_READY ? wd + 1'b1 : '0;
            if (to_fire) err_q <= 1'b1;
        end
    end
    // a ready arriving on the last allowed cycle still wins over the watchdog
    assign to_fire = state == WAIT_READY && !readyxSI && wd == TW'(TO_CYC - 1);
    assign host.err = err_q;
`else
    assign to_fire = 1'b0;
    assign host.err = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else state <= state_n;
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:       state_n = host.job_valid ? DRST : IDLE;
            DRST:       state_n = STREAM;
            STREAM:     state_n = cnt == CNTW'(NS - 1) ? ARM : STREAM;
            ARM:        state_n = START;
            START:      state_n = WAIT_READY;
            WAIT_READY: state_n = readyxSI ? COLLECT : to_fire ? IDLE : WAIT_READY;
            COLLECT:    state_n = ready_d && cnt == CNTW'(L - 1) ? IDLE : COLLECT;
            default:    state_n = IDLE;
        endcase
    end
    // rst_pend stretches the core reset over the host reset and one cycle after a watchdog abort
    always_comb begin
        host.job_ready = state == IDLE;
        dut_rstxSO = state == DRST || rst_pend;
        startxSO = state == START;
        messagexSO = shift ? msg_bits : 3'b000;
        r_64xSO = shift ? rnd_bits : 7'b0;
        r_faultxSO = shift && flt_bit;
    end
    // the core shows bit j one cycle after sampling ready, so capture follows the registered ready
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
            ready_d <= 1'b0;
            rst_pend <= 1'b1;
            host.hash <= '0;
            host.hash_valid <= 1'b0;
        end else begin
            ready_d <= readyxSI;
            rst_pend <= to_fire;
            host.hash_valid <= state == COLLECT && ready_d && cnt == CNTW'(L - 1);
            if (state == DRST || state == WAIT_READY) cnt <= '0;
            else if (state == STREAM || (state == COLLECT && ready_d)) cnt <= cnt + 1'b1;
            if (state == COLLECT && ready_d) host.hash[cnt[HW-1:0]] <= hash_textxSI;
        end
    end
endmodule

// File: tb/tb_ascon_hash_serial_host.sv
// tb_ascon_hash_serial_host: self-checking bench for ascon_hash_serial_host with a serial core model and hash scoreboard
module tb_ascon_hash_serial_host;
    localparam int Y = 32;
    localparam int L = 256;
    localparam int RW = 64;
    localparam int N = (Y > L) ? ((Y > RW) ? Y : RW) : ((L > RW) ? L : RW);

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic dut_rstxSO;
    logic [2:0] messagexSO;
    logic [6:0] r_64xSO;
    logic r_faultxSO;
    logic startxSO;
    logic hash_textxSI = 1'b0;
    logic readyxSI = 1'b0;
    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    logic [L-1:0] sb[$];
    logic [L-1:0] prev_hash = '0;

    ascon_hash_serial_host_if #(.Y(Y), .L(L), .RW(RW)) bus ();

    ascon_hash_serial_host #(
        .Y(Y), .L(L), .RW(RW)
`ifdef ASCON_HOST_TIMEOUT_EN
        , .TO_CYC(16)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .host(bus),
        .dut_rstxSO(dut_rstxSO),
        .messagexSO(messagexSO),
        .r_64xSO(r_64xSO),
        .r_faultxSO(r_faultxSO),
        .startxSO(startxSO),
        .hash_textxSI(hash_textxSI),
        .readyxSI(readyxSI)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [7*RW-1:0] rand_rnd();
        logic [7*RW-1:0] v;
        for (int i = 0; i < 7 * RW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [L-1:0] rand_l();
        logic [L-1:0] v;
        for (int i = 0; i < L / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic handshake(input logic [Y-1:0] m, k1, k2, input logic [7*RW-1:0] r, input logic [L-1:0] rf, output int t_hs);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.job_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (bus.job_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL job_ready_wait: got %b want 1", bus.job_ready);
        end
        bus.msg = m;
        bus.msk1 = k1;
        bus.msk2 = k2;
        bus.rnd = r;
        bus.rfault = rf;
        bus.job_valid = 1'b1;
        t_hs = cyc;
        @(negedge clk);
        bus.job_valid = 1'b0;
    endtask

    task automatic run_job(input logic [Y-1:0] m, k1, k2, input logic [7*RW-1:0] r, input logic [L-1:0] rf, h, input int stall_at, stall_len);
        logic [N-1:0] s0, s1, s2, sf, e;
        logic [N-1:0] sr [7];
        logic [L-1:0] want;
        int t_hs, t_rdy, n, j, stalled;
        bit bad;
        handshake(m, k1, k2, r, rf, t_hs);
        sb.push_back(h);
        vectors++;
        if (dut_rstxSO !== 1'b1 || startxSO !== 1'b0 || bus.job_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL drst: got rst=%b start=%b ready=%b want 1 0 0", dut_rstxSO, startxSO, bus.job_ready);
        end
        vectors++;
        if (bus.hash !== prev_hash) begin
            miscompares++;
            $display("FAIL hash_hold: got %h want %h", bus.hash, prev_hash);
        end
        s0 = '0; s1 = '0; s2 = '0; sf = '0; bad = 1'b0;
        for (int k = 0; k < 7; k++) sr[k] = '0;
        for (int c = 0; c < N; c++) begin
            @(negedge clk);
            s0 = {s0[N-2:0], messagexSO[0]};
            s1 = {s1[N-2:0], messagexSO[1]};
            s2 = {s2[N-2:0], messagexSO[2]};
            sf = {sf[N-2:0], r_faultxSO};
            for (int k = 0; k < 7; k++) sr[k] = {sr[k][N-2:0], r_64xSO[k]};
            bad |= dut_rstxSO !== 1'b0 || startxSO !== 1'b0;
        end
        e = '0; e[N-1 -: Y] = m;
        vectors++;
        if (s0 !== e) begin miscompares++; $display("FAIL msg_stream: got %h want %h", s0, e); end
        e = '0; e[N-1 -: Y] = k1;
        vectors++;
        if (s1 !== e) begin miscompares++; $display("FAIL msk1_stream: got %h want %h", s1, e); end
        e = '0; e[N-1 -: Y] = k2;
        vectors++;
        if (s2 !== e) begin miscompares++; $display("FAIL msk2_stream: got %h want %h", s2, e); end
        e = '0; e[N-1 -: L] = rf;
        vectors++;
        if (sf !== e) begin miscompares++; $display("FAIL rfault_stream: got %h want %h", sf, e); end
        for (int k = 0; k < 7; k++) begin
            e = '0; e[N-1 -: RW] = r[k*RW +: RW];
            vectors++;
            if (sr[k] !== e) begin miscompares++; $display("FAIL rnd%0d_stream: got %h want %h", k, sr[k], e); end
        end
        vectors++;
        if (bad) begin miscompares++; $display("FAIL stream_ctrl: got rst/start active during stream want 0"); end
        @(negedge clk);
        vectors++;
        if ({messagexSO, r_64xSO, r_faultxSO, startxSO, dut_rstxSO} !== 13'b0) begin
            miscompares++;
            $display("FAIL arm_idle: got %b want 0", {messagexSO, r_64xSO, r_faultxSO, startxSO, dut_rstxSO});
        end
        @(negedge clk);
        // start sits N+2 cycles after the DRST cycle, i.e. N+3 after the handshake cycle
        vectors++;
        if (startxSO !== 1'b1 || cyc - t_hs != N + 3) begin
            miscompares++;
            $display("FAIL start_timing: got start=%b at %0d want 1 at %0d", startxSO, cyc - t_hs, N + 3);
        end
        repeat (4) @(negedge clk);
        readyxSI = 1'b1;
        t_rdy = cyc;
        j = 0; stalled = 0; n = 0;
        while (n < L + 64) begin
            @(negedge clk);
            n++;
            if (bus.hash_valid === 1'b1) break;
            if (readyxSI) begin
                hash_textxSI = h[j];
                j++;
            end
            if (j == stall_at && stalled < stall_len) begin
                readyxSI = 1'b0;
                stalled++;
            end else begin
                readyxSI = j < L;
            end
        end
        readyxSI = 1'b0;
        want = sb.pop_front();
        vectors++;
        if (bus.hash_valid !== 1'b1 || cyc - t_rdy != L + 1 + stall_len) begin
            miscompares++;
            $display("FAIL hash_valid_timing: got valid=%b at %0d want 1 at %0d", bus.hash_valid, cyc - t_rdy, L + 1 + stall_len);
        end
        vectors++;
        if (bus.hash !== want) begin
            miscompares++;
            $display("FAIL hash_value: got %h want %h", bus.hash, want);
        end
        prev_hash = want;
        @(negedge clk);
        vectors++;
        if (bus.hash_valid !== 1'b0 || bus.job_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL hash_valid_pulse: got valid=%b ready=%b want 0 1", bus.hash_valid, bus.job_ready);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        vectors++;
        if (bus.job_ready !== 1'b1 || dut_rstxSO !== 1'b1 || {messagexSO, r_64xSO, r_faultxSO, startxSO} !== 12'b0 ||
            bus.hash !== '0 || bus.hash_valid !== 1'b0 || bus.err !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: got ready=%b drst=%b ser=%b hv=%b err=%b hash=%h want 1 1 0 0 0 0", name, bus.job_ready,
                     dut_rstxSO, {messagexSO, r_64xSO, r_faultxSO, startxSO}, bus.hash_valid, bus.err, bus.hash);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_state");
        rst = 1'b1;
        prev_hash = '0;
    endtask

    task automatic test_msg_stream();
        run_job(32'h8000_0001, $urandom, $urandom, rand_rnd(), rand_l(), rand_l(), 0, 0);
    endtask

    task automatic test_rnd_stream();
        logic [7*RW-1:0] r;
        r = '0;
        r[3*RW +: RW] = 64'hF000_0000_0000_0000;
        run_job($urandom, $urandom, $urandom, r, '0, rand_l(), 0, 0);
    endtask

    task automatic test_hash_collect();
        logic [L-1:0] h;
        h = '0;
        h[3:0] = 4'h5;
        run_job($urandom, $urandom, $urandom, rand_rnd(), rand_l(), h, 0, 0);
    endtask

    task automatic test_ready_stall();
        run_job($urandom, $urandom, $urandom, rand_rnd(), rand_l(), rand_l(), 100, 3);
    endtask

    task automatic test_reset_mid_job();
        int t_hs, seen;
        handshake($urandom, $urandom, $urandom, rand_rnd(), rand_l(), t_hs);
        for (int c = 0; c <= 100; c++) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset_mid_job");
        rst = 1'b1;
        prev_hash = '0;
        seen = 0;
        repeat (N + 40) begin
            @(negedge clk);
            if (bus.hash_valid !== 1'b0 || startxSO !== 1'b0) seen++;
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL abort_quiet: got %0d active cycles want 0", seen);
        end
        run_job($urandom, $urandom, $urandom, rand_rnd(), rand_l(), rand_l(), 0, 0);
    endtask

    task automatic test_back_to_back();
        run_job($urandom, $urandom, $urandom, rand_rnd(), rand_l(), rand_l(), 0, 0);
        run_job($urandom, $urandom, $urandom, rand_rnd(), rand_l(), rand_l(), 50, 1);
    endtask

`ifdef ASCON_HOST_TIMEOUT_EN
    task automatic test_timeout();
        int t_hs;
        handshake($urandom, $urandom, $urandom, rand_rnd(), rand_l(), t_hs);
        repeat (N + 2) @(negedge clk);
        vectors++;
        if (startxSO !== 1'b1) begin miscompares++; $display("FAIL to_start: got %b want 1", startxSO); end
        repeat (16) @(negedge clk);
        vectors++;
        if (bus.err !== 1'b0) begin miscompares++; $display("FAIL to_early: got err=%b want 0", bus.err); end
        @(negedge clk);
        vectors++;
        if (bus.err !== 1'b1 || dut_rstxSO !== 1'b1 || bus.job_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL to_fire: got err=%b drst=%b ready=%b want 1 1 1", bus.err, dut_rstxSO, bus.job_ready);
        end
        @(negedge clk);
        vectors++;
        if (bus.err !== 1'b1 || dut_rstxSO !== 1'b0 || bus.hash_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL to_after: got err=%b drst=%b hv=%b want 1 0 0", bus.err, dut_rstxSO, bus.hash_valid);
        end
        test_reset();
    endtask
`endif

    initial begin
        bus.job_valid = 1'b0;
        bus.msg = '0;
        bus.msk1 = '0;
        bus.msk2 = '0;
        bus.rnd = '0;
        bus.rfault = '0;
        test_reset();
        test_msg_stream();
        test_rnd_stream();
        test_hash_collect();
        test_ready_stall();
        test_reset_mid_job();
        test_back_to_back();
`ifdef ASCON_HOST_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
